// File: rtl/adder_share_sequencer.sv
// Two-requester arbiter that runs 32-bit add/sub as two passes through one
// shared 16-bit adder. Define ARB_FIXED_PRIO_EN for fixed priority (req 0 wins).
module adder_share_sequencer #(
   parameter int ADD_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req,
   input  logic [1:0]         sub,
   input  logic [2*ADD_W-1:0] op_a0,
   input  logic [2*ADD_W-1:0] op_b0,
   input  logic [2*ADD_W-1:0] op_a1,
   input  logic [2*ADD_W-1:0] op_b1,
   output logic [1:0]         ack,
   output logic [1:0]         done,
   output logic [2*ADD_W-1:0] result,
   output logic               cout,
   output logic               ovf,
   output logic [ADD_W-1:0]   add_in1,
   output logic [ADD_W-1:0]   add_in2,
   output logic               add_cin,
   input  logic [ADD_W-1:0]   add_sum,
   input  logic               add_cout
);

   localparam int W = 2 * ADD_W;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } state_t;

   state_t           state;
   state_t           nxt;
   logic [W-1:0]     a_q;
   logic [W-1:0]     bx_q;
   logic             sub_q;
   logic             owner_q;
   logic             c16_q;
   logic [ADD_W-1:0] lo_q;
   logic [1:0]       grant;
   logic             win;
   logic [W-1:0]     sel_a;
   logic [W-1:0]     sel_b;
   logic             sel_sub;
`ifndef ARB_FIXED_PRIO_EN
   logic             last_q;
`endif

   always_comb begin
      grant = 2'b00;
`ifdef ARB_FIXED_PRIO_EN
      if (req[0]) begin
         grant = 2'b01;
      end else if (req[1]) begin
         grant = 2'b10;
      end
`else
      // A lone request is already one-hot; a tie goes to the other side.
      if (req == 2'b11) begin
         grant = last_q ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
`endif
   end

   assign win     = grant[1];
   assign sel_a   = win ? op_a1 : op_a0;
   assign sel_b   = win ? op_b1 : op_b0;
   assign sel_sub = win ? sub[1] : sub[0];

   always_comb begin
      nxt     = state;
      ack     = 2'b00;
      done    = 2'b00;
      add_in1 = '0;
      add_in2 = '0;
      add_cin = 1'b0;
      unique case (state)
         IDLE: begin
            if (|req && !rst) begin
               ack = grant;
               nxt = LO;
            end
         end
         LO: begin
            add_in1 = a_q[ADD_W-1:0];
            add_in2 = bx_q[ADD_W-1:0];
            add_cin = sub_q;
            nxt     = HI;
         end
         HI: begin
            add_in1 = a_q[W-1:ADD_W];
            add_in2 = bx_q[W-1:ADD_W];
            add_cin = c16_q;
            nxt     = DONE;
         end
         DONE: begin
            done = owner_q ? 2'b10 : 2'b01;
            nxt  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         a_q     <= '0;
         bx_q    <= '0;
         sub_q   <= 1'b0;
         owner_q <= 1'b0;
         c16_q   <= 1'b0;
         lo_q    <= '0;
         result  <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state <= nxt;
         unique case (state)
            IDLE: begin
               if (|req) begin
                  a_q     <= sel_a;
                  // Subtract is A + ~B + 1; keep B already inverted.
                  bx_q    <= sel_sub ? ~sel_b : sel_b;
                  sub_q   <= sel_sub;
                  owner_q <= win;
`ifndef ARB_FIXED_PRIO_EN
                  last_q  <= win;
`endif
               end
            end
            LO: begin
               lo_q  <= add_sum;
               c16_q <= add_cout;
            end
            HI: begin
               result <= {add_sum, lo_q};
               cout   <= add_cout;
               ovf    <= (a_q[W-1] == bx_q[W-1]) &&
                         (add_sum[ADD_W-1] != a_q[W-1]);
            end
            DONE: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_share_sequencer.sv
// Bench for adder_share_sequencer: behavioural adder plus an arithmetic and
// arbitration reference model; honours ARB_FIXED_PRIO_EN like the design.
module tb_adder_share_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  sub;
   logic [31:0] op_a0;
   logic [31:0] op_b0;
   logic [31:0] op_a1;
   logic [31:0] op_b1;
   logic [1:0]  ack;
   logic [1:0]  done;
   logic [31:0] result;
   logic        cout;
   logic        ovf;
   logic [15:0] add_in1;
   logic [15:0] add_in2;
   logic        add_cin;
   logic [15:0] add_sum;
   logic        add_cout;

   int checks = 0;
   int errors = 0;
   int last_g = 1;

   localparam longint MAXS = 64'sh7FFFFFFF;
   localparam longint MINS = -64'sh80000000;

   typedef struct packed {
      logic [1:0]  ack_t;
      logic [1:0]  done_q;
      logic [15:0] in1_lo;
      logic [15:0] in2_lo;
      logic        cin_lo;
      logic [15:0] in1_hi;
      logic [15:0] in2_hi;
      logic        cin_hi;
      logic [1:0]  done_t;
      logic [31:0] res;
      logic        c;
      logic        v;
      logic [1:0]  ack_dn;
      logic [32:0] in_dn;
   } obs_t;

   adder_share_sequencer #(.ADD_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .sub      (sub),
      .op_a0    (op_a0),
      .op_b0    (op_b0),
      .op_a1    (op_a1),
      .op_b1    (op_b1),
      .ack      (ack),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .ovf      (ovf),
      .add_in1  (add_in1),
      .add_in2  (add_in2),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2}
                              + {16'h0, add_cin};

   always #5 clk = ~clk;

   function automatic int ref_arb(input logic [1:0] rq);
`ifdef ARB_FIXED_PRIO_EN
      return rq[0] ? 0 : 1;
`else
      if (rq == 2'b11) return (last_g == 0) ? 1 : 0;
      return rq[0] ? 0 : 1;
`endif
   endfunction

   function automatic obs_t model_op(input logic [1:0] rq,
                                     input logic [1:0] sb,
                                     input logic [31:0] a0, b0, a1, b1);
      obs_t e;
      int w;
      logic [31:0] a, b, bx;
      logic s;
      longint sa, sv, ex;
      longint unsigned ua, ub;
      e = '0;
      w = ref_arb(rq);
      a = (w == 1) ? a1 : a0;
      b = (w == 1) ? b1 : b0;
      s = sb[w];
      bx = s ? ~b : b;
      sa = $signed(a);
      sv = $signed(b);
      ex = s ? sa - sv : sa + sv;
      ua = a;
      ub = b;
      e.ack_t  = (w == 1) ? 2'b10 : 2'b01;
      e.done_t = e.ack_t;
      e.in1_lo = a[15:0];
      e.in2_lo = bx[15:0];
      e.cin_lo = s;
      e.in1_hi = a[31:16];
      e.in2_hi = bx[31:16];
      e.cin_hi = s ? (a[15:0] >= b[15:0])
                   : ((int'(a[15:0]) + int'(b[15:0])) > 65535);
      e.res = ex[31:0];
      e.c   = s ? (a >= b) : (((ua + ub) >> 32) != 0);
      e.v   = (ex > MAXS) || (ex < MINS);
      return e;
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 5))
         0: return 32'hFFFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'h7FFF_FFFF;
         3: return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input logic [1:0] rq, input logic [1:0] sb,
                         input logic [31:0] a0, b0, a1, b1,
                         input bit hold, output obs_t o);
      o = '0;
      @(negedge clk);
      req = rq;
      sub = sb;
      op_a0 = a0;
      op_b0 = b0;
      op_a1 = a1;
      op_b1 = b1;
      #1 o.ack_t = ack;
      @(negedge clk);
      if (!hold) req = 2'b00;
      sub = ~sb;
      op_a0 = $urandom;
      op_b0 = $urandom;
      op_a1 = $urandom;
      op_b1 = $urandom;
      #1;
      o.in1_lo = add_in1;
      o.in2_lo = add_in2;
      o.cin_lo = add_cin;
      o.done_q = done;
      @(negedge clk);
      #1;
      o.in1_hi = add_in1;
      o.in2_hi = add_in2;
      o.cin_hi = add_cin;
      o.done_q = o.done_q | done;
      @(negedge clk);
      #1;
      o.done_t = done;
      o.res    = result;
      o.c      = cout;
      o.v      = ovf;
      o.ack_dn = ack;
      o.in_dn  = {add_in1, add_in2, add_cin};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 2'b11;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (ack !== 2'b00) begin
         errors++;
         $display("FAIL rst_ack got %b want 00", ack);
      end
      checks++;
      if (done !== 2'b00) begin
         errors++;
         $display("FAIL rst_done got %b want 00", done);
      end
      checks++;
      if ({result, cout, ovf} !== 34'h0) begin
         errors++;
         $display("FAIL rst_out got %h %b %b want 0", result, cout, ovf);
      end
      checks++;
      if ({add_in1, add_in2, add_cin} !== 33'h0) begin
         errors++;
         $display("FAIL rst_adder got %h %h %b want 0",
                  add_in1, add_in2, add_cin);
      end
      @(negedge clk);
      req = 2'b00;
      rst = 1'b0;
      last_g = 1;
   endtask

   typedef struct {
      bit r;
      bit s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      bit c;
      bit v;
      bit hold;
   } dcase_t;

   task automatic test_directed();
      dcase_t t[5];
      obs_t o, e;
      logic [1:0] rq, sb;
      logic [31:0] a0, b0, a1, b1;
      t[0] = '{0, 0, 32'h0001_FFFF, 32'h1, 32'h0002_0000, 0, 0, 0};
      t[1] = '{1, 1, 32'h0000_0000, 32'h1, 32'hFFFF_FFFF, 0, 0, 0};
      t[2] = '{0, 0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 0};
      t[3] = '{0, 0, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 1, 0, 1};
      t[4] = '{1, 1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
         rq = t[i].r ? 2'b10 : 2'b01;
         sb = t[i].r ? {t[i].s, 1'($urandom)} : {1'($urandom), t[i].s};
         a0 = t[i].r ? $urandom : t[i].a;
         b0 = t[i].r ? $urandom : t[i].b;
         a1 = t[i].r ? t[i].a : $urandom;
         b1 = t[i].r ? t[i].b : $urandom;
         e = model_op(rq, sb, a0, b0, a1, b1);
         run_op(rq, sb, a0, b0, a1, b1, t[i].hold, o);
         last_g = t[i].r ? 1 : 0;
         checks++;
         if (o.ack_t !== e.ack_t) begin
            errors++;
            $display("FAIL dir%0d_ack got %b want %b", i, o.ack_t, e.ack_t);
         end
         checks++;
         if (o.done_t !== e.done_t) begin
            errors++;
            $display("FAIL dir%0d_done got %b want %b",
                     i, o.done_t, e.done_t);
         end
         checks++;
         if (o.res !== t[i].res) begin
            errors++;
            $display("FAIL dir%0d_res got %h want %h", i, o.res, t[i].res);
         end
         checks++;
         if ({o.c, o.v} !== {t[i].c, t[i].v}) begin
            errors++;
            $display("FAIL dir%0d_cv got %b%b want %b%b",
                     i, o.c, o.v, t[i].c, t[i].v);
         end
         checks++;
         if ({o.in1_lo, o.in2_lo, o.cin_lo} !==
             {e.in1_lo, e.in2_lo, e.cin_lo}) begin
            errors++;
            $display("FAIL dir%0d_lo got %h %h %b want %h %h %b", i,
                     o.in1_lo, o.in2_lo, o.cin_lo,
                     e.in1_lo, e.in2_lo, e.cin_lo);
         end
         checks++;
         if ({o.in1_hi, o.in2_hi, o.cin_hi} !==
             {e.in1_hi, e.in2_hi, e.cin_hi}) begin
            errors++;
            $display("FAIL dir%0d_hi got %h %h %b want %h %h %b", i,
                     o.in1_hi, o.in2_hi, o.cin_hi,
                     e.in1_hi, e.in2_hi, e.cin_hi);
         end
         checks++;
         if ({o.done_q, o.ack_dn, o.in_dn} !== 37'h0) begin
            errors++;
            $display("FAIL dir%0d_quiet got %b %b %h want 0",
                     i, o.done_q, o.ack_dn, o.in_dn);
         end
      end
      req = 2'b00;
   endtask

   task automatic test_reset_midop();
      obs_t o, e;
      logic [1:0] seq [3];
      logic [31:0] a0, b0, a1, b1;
`ifdef ARB_FIXED_PRIO_EN
      seq = '{2'b01, 2'b01, 2'b01};
`else
      seq = '{2'b01, 2'b10, 2'b01};
`endif
      @(negedge clk);
      req = 2'b01;
      sub = 2'b00;
      op_a0 = 32'h1234_5678;
      op_b0 = 32'h1111_1111;
      #1;
      checks++;
      if (ack !== 2'b01) begin
         errors++;
         $display("FAIL mid_ack got %b want 01", ack);
      end
      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({done, result, cout, ovf, add_in1, add_in2, add_cin} !== 69'h0)
      begin
         errors++;
         $display("FAIL mid_clear got %b %h %b %b %h %h %b want 0",
                  done, result, cout, ovf, add_in1, add_in2, add_cin);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done !== 2'b00) begin
         errors++;
         $display("FAIL mid_nodone got %b want 00", done);
      end
      rst = 1'b0;
      last_g = 1;
      for (int i = 0; i < 3; i++) begin
         a0 = rnd_op();
         b0 = rnd_op();
         a1 = rnd_op();
         b1 = rnd_op();
         e = model_op(2'b11, 2'b01, a0, b0, a1, b1);
         run_op(2'b11, 2'b01, a0, b0, a1, b1, 1'b1, o);
         last_g = e.ack_t[1] ? 1 : 0;
         checks++;
         if (o.ack_t !== seq[i]) begin
            errors++;
            $display("FAIL rr%0d_ack got %b want %b", i, o.ack_t, seq[i]);
         end
         checks++;
         if (o.done_t !== seq[i]) begin
            errors++;
            $display("FAIL rr%0d_done got %b want %b", i, o.done_t, seq[i]);
         end
         checks++;
         if ({o.res, o.c, o.v} !== {e.res, e.c, e.v}) begin
            errors++;
            $display("FAIL rr%0d_res got %h %b%b want %h %b%b", i,
                     o.res, o.c, o.v, e.res, e.c, e.v);
         end
         checks++;
         if ({o.done_q, o.ack_dn} !== 4'h0) begin
            errors++;
            $display("FAIL rr%0d_quiet got %b %b want 0",
                     i, o.done_q, o.ack_dn);
         end
      end
      req = 2'b00;
   endtask

   task automatic test_random();
      obs_t o, e;
      logic [1:0] rq, sb;
      logic [31:0] a0, b0, a1, b1;
      bit hold;
      for (int i = 0; i < 60; i++) begin
         rq = 2'($urandom_range(1, 3));
         sb = 2'($urandom);
         hold = 1'($urandom);
         a0 = rnd_op();
         b0 = rnd_op();
         a1 = rnd_op();
         b1 = rnd_op();
         e = model_op(rq, sb, a0, b0, a1, b1);
         run_op(rq, sb, a0, b0, a1, b1, hold, o);
         last_g = e.ack_t[1] ? 1 : 0;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rnd%0d rq=%b sb=%b got %h want %h",
                     i, rq, sb, o, e);
         end
         req = 2'b00;
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 2'b00;
      sub = 2'b00;
      op_a0 = '0;
      op_b0 = '0;
      op_a1 = '0;
      op_b1 = '0;
      test_reset();
      test_directed();
      test_reset_midop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_share_sequencer.md
Name: adder_share_sequencer

Overview:
- Two-requester arbiter and sequencer for one shared 16-bit carry-lookahead adder.
- Each granted request runs a 32-bit add or subtract as two 16-bit passes through the adder: low half first, then high half.
- The adder is purely combinational. This block drives its in1/in2/carryIn and samples sum/carry in the same cycle.
- Sits between the ALU/address-generation requesters and the adder instance in the processor datapath.

Parameters:
- ADD_W, 16, shared adder width; operand/result width is 2*ADD_W. Only 16 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- req  in  2  per-requester request; held high until ack.
- sub  in  2  per-requester op select; 1 = subtract (A-B), 0 = add.
- op_a0  in  32  requester 0 operand A.
- op_b0  in  32  requester 0 operand B.
- op_a1  in  32  requester 1 operand A.
- op_b1  in  32  requester 1 operand B.
- ack  out  2  one-hot, 1-cycle pulse; the granted requester's operands are captured this cycle.
- done  out  2  one-hot, 1-cycle pulse; result valid for that requester.
- result  out  32  sum/difference; held until the next done.
- cout  out  1  carry out of bit 31 (for sub: 1 = no borrow).
- ovf  out  1  signed overflow of the 32-bit operation.
- add_in1  out  16  to adder in1.
- add_in2  out  16  to adder in2.
- add_cin  out  1  to adder carryIn.
- add_sum  in  16  from adder sum.
- add_cout  in  1  from adder carry.

Behaviour:
- Reset values: state=IDLE; ack=0; done=0; result=0; cout=0; ovf=0; add_in1/add_in2/add_cin=0; last_grant=1, so requester 0 wins the first contest.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If any req bit is high, select a winner and pulse ack for the winner.
  - Capture the winner's A, B and sub; set owner; go to LO.
  - If no req bit is high, stay in IDLE.
- Arbitration is round-robin:
  - If both request, grant the one not equal to last_grant, then update last_grant.
  - A single request is granted immediately.
- LO:
  - Drive add_in1=A[15:0], add_in2=(sub ? ~B[15:0] : B[15:0]), add_cin=sub.
  - Register lo_sum=add_sum and c16=add_cout. Go to HI.
- HI:
  - Drive add_in1=A[31:16], add_in2=(sub ? ~B[31:16] : B[31:16]), add_cin=c16.
  - Register result={add_sum, lo_sum}, cout=add_cout.
  - Register ovf=(A[31]==B'[31]) && (add_sum[15]!=A[31]), where B' is the inverted-or-not B.
  - Go to DONE.
- DONE:
  - done[owner]=1 for exactly this cycle. Go to IDLE.
  - No ack is issued in DONE.
- Outside LO/HI, add_in1/add_in2/add_cin are driven to 0.
- Latency: ack at cycle T, done at T+3. Throughput is one op per 4 cycles.
- A requester keeping req high after its own ack is treated as a new request, competing again in the next IDLE.
- Operand changes after ack have no effect on the in-flight op.
- Wrap-around:
  - 0xFFFFFFFF+1 gives result=0, cout=1, ovf=0.
  - Carry out of the low pass propagates only via c16.
- Reset asserted mid-operation:
  - Return to IDLE immediately; no done for the aborted op.
  - result/cout/ovf are cleared to 0 and last_grant is set to 1.
- ack and done are never high for both bits at once; at most one of ack or done is high in any cycle.

Optional Feature:
- ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. Requester 0 always wins a simultaneous request; last_grant is unused, and requester 1 can starve.
  - Undefined (default): round-robin as above.

Test Plan:
- Single add: req=01, A=0x0001FFFF, B=0x00000001, sub=0 -> ack=01 at T; done=01 at T+3; result=0x00020000, cout=0, ovf=0; LO-cycle add_cin=0, HI-cycle add_cin=1.
- Subtract with borrow: req=10, A=0x00000000, B=0x00000001, sub=1 -> done=10; result=0xFFFFFFFF, cout=0, ovf=0.
- Overflow: A=0x7FFFFFFF, B=0x00000001, add -> result=0x80000000, ovf=1, cout=0. A=0x80000000, B=0x00000001, sub -> result=0x7FFFFFFF, ovf=1, cout=1.
- Contention: both req held high for 3 ops -> ack order 01,10,01 (round-robin); with ARB_FIXED_PRIO_EN -> 01,01,01. Each done matches its ack, 3 cycles later.
- Reset mid-op: assert rst during HI -> no done pulse; outputs are 0 next cycle. After release, req=11 -> ack=01 first.
- Wrap: A=0xFFFFFFFF, B=0x00000001, add -> result=0x00000000, cout=1, ovf=0; no ack is issued in the DONE cycle even with req held.
